// File: rtl/ram_axis_reader.sv
// ram_axis_reader: streams words 0..count-1 of a Ram buffer out as an AXI4-Stream master.
// Define RAM_AXIS_READER_TLAST_EN to add the m_axis_tlast port.
module ram_axis_reader #(
  parameter int WORD_SIZE = 8,
  parameter int LENGTH_SIZE = 784,
  localparam int ADR_SIZE = $clog2(LENGTH_SIZE)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [ADR_SIZE:0]    count,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_rd,
  output logic [ADR_SIZE-1:0]  ram_adr,
  input  logic [WORD_SIZE-1:0] ram_data,
  output logic [WORD_SIZE-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready
`ifdef RAM_AXIS_READER_TLAST_EN
  ,
  output logic                 m_axis_tlast
`endif
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  localparam logic [ADR_SIZE:0] one = 1;
  localparam logic [ADR_SIZE:0] max_cnt = LENGTH_SIZE;
  state_t state, state_nxt;
  logic [ADR_SIZE:0] cnt, fa, sent;
  logic fetch, hs;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign ram_rd = fetch;
  assign ram_adr = fa[ADR_SIZE-1:0];
  // fetch may refill the output register in the same cycle it is drained
  always_comb begin
    fetch = state == STREAM && fa < cnt && (!m_axis_tvalid || m_axis_tready);
    hs = m_axis_tvalid && m_axis_tready;
    state_nxt = state == IDLE ? (start ? (count == '0 ? DONE : STREAM) : IDLE) :
                state == STREAM ? (hs && sent + one == cnt ? DONE : STREAM) : IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      fa <= '0;
      sent <= '0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
`ifdef RAM_AXIS_READER_TLAST_EN
      m_axis_tlast <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        cnt <= count > max_cnt ? max_cnt : count;
        fa <= '0;
        sent <= '0;
      end
      if (fetch) begin
        m_axis_tdata <= ram_data;
        m_axis_tvalid <= 1'b1;
        fa <= fa + one;
`ifdef RAM_AXIS_READER_TLAST_EN
        m_axis_tlast <= fa == cnt - one;
`endif
      end else if (hs) begin
        m_axis_tvalid <= 1'b0;
      end
      if (hs) sent <= sent + one;
    end
  end
endmodule
